// File: rtl/add_serial_arbiter.sv
// add_serial_arbiter: shares one bit-serial add_serial adder among NREQ
// requesters. Round-robin grant, launch pulse, fixed-latency wait, sum
// capture, release pulse, then a tagged response held until accepted.
// Optional build macro: ADD_ARB_PRIO0_EN gives requester 0 fixed top
// priority; the remaining requesters round-robin among themselves.
module add_serial_arbiter #(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 8,
  parameter int ADD_LATENCY = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     req_a,
  input  logic [NREQ*WIDTH-1:0]     req_b,
  output logic [NREQ-1:0]           gnt,
  output logic                      add_en,
  output logic [WIDTH-1:0]          add_a,
  output logic [WIDTH-1:0]          add_b,
  input  logic [WIDTH-1:0]          add_out,
  output logic                      rsp_valid,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [WIDTH-1:0]          rsp_data,
  input  logic                      rsp_ready
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(ADD_LATENCY + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  localparam logic [CW-1:0] LAT_LAST = CW'(ADD_LATENCY - 1);

  logic [2:0]       state;
  logic [IW-1:0]    rr_ptr;
  logic [CW-1:0]    lat_cnt;
  logic             found;
  logic [IW-1:0]    winner;
  logic [IW-1:0]    rr_next;
  logic [WIDTH-1:0] op_a [NREQ];
  logic [WIDTH-1:0] op_b [NREQ];

  // Unpack the flat operand buses into per-requester slices.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = req_a[i*WIDTH +: WIDTH];
      op_b[i] = req_b[i*WIDTH +: WIDTH];
    end
  end

  // Winner search: first requesting index at or after rr_ptr, wrapping.
  always_comb begin
    logic [IW:0]   pos;
    logic [IW-1:0] cand;
    found  = 1'b0;
    winner = '0;
    pos    = '0;
    cand   = '0;
`ifdef ADD_ARB_PRIO0_EN
    if (req[0]) begin
      found  = 1'b1;
      winner = '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        pos = {1'b0, rr_ptr} + (IW+1)'(k);
        if (pos >= (IW+1)'(NREQ)) pos = pos - (IW+1)'(NREQ);
        cand = pos[IW-1:0];
        if (!found && cand != '0 && req[cand]) begin
          found  = 1'b1;
          winner = cand;
        end
      end
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, rr_ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(NREQ)) pos = pos - (IW+1)'(NREQ);
      cand = pos[IW-1:0];
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
`endif
  end

  assign rr_next = (winner == IW'(NREQ - 1)) ? '0 : winner + IW'(1);

  // Grant pulse, adder enable and response valid decode from the state.
  always_comb begin
    gnt = '0;
    if (state == S_ISSUE) gnt[rsp_id] = 1'b1;
    add_en    = (state == S_ISSUE) || (state == S_RELEASE);
    rsp_valid = (state == S_RESP);
  end

  // Sequencer: grant, launch, latency wait, capture, release, respond.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      lat_cnt  <= '0;
      add_a    <= '0;
      add_b    <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            // Operands stay registered until the next grant: the adder
            // keeps sampling operand bits while it shifts.
            add_a  <= op_a[winner];
            add_b  <= op_b[winner];
            rsp_id <= winner;
`ifdef ADD_ARB_PRIO0_EN
            if (winner != '0) rr_ptr <= rr_next;
`else
            rr_ptr <= rr_next;
`endif
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          lat_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          lat_cnt <= lat_cnt + CW'(1);
          // add_out is only meaningful on the last latency cycle.
          if (lat_cnt == LAT_LAST) begin
            rsp_data <= add_out;
            state    <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          state <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_serial_arbiter.sv
// Testbench for add_serial_arbiter: random and directed requests, checked
// cycle by cycle against a schedule-level reference model, with a
// behavioural stand-in for the serial adder that only presents the true sum
// on the cycle ADD_LATENCY after launch.
module tb_add_serial_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int LAT   = 11;
  localparam int IW    = $clog2(NREQ);

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       gnt;
  logic                  add_en;
  logic [WIDTH-1:0]      add_a;
  logic [WIDTH-1:0]      add_b;
  logic [WIDTH-1:0]      add_out;
  logic                  rsp_valid;
  logic [IW-1:0]         rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_ready;

  add_serial_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .ADD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .add_en(add_en), .add_a(add_a), .add_b(add_b),
    .add_out(add_out), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  // Adder stand-in: first add_en launches, second releases. The sum is
  // visible only on the exact valid cycle; other cycles show junk.
  logic             am_busy;
  int               am_cnt;
  logic [WIDTH-1:0] am_sum;
  logic [WIDTH-1:0] am_junk;

  always @(posedge clk) am_junk <= WIDTH'($urandom);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      am_busy <= 1'b0;
      am_cnt  <= 0;
      am_sum  <= '0;
    end else if (add_en) begin
      if (!am_busy) begin
        am_busy <= 1'b1;
        am_cnt  <= 1;
        am_sum  <= add_a + add_b;
      end else begin
        am_busy <= 1'b0;
      end
    end else if (am_busy) begin
      am_cnt <= am_cnt + 1;
    end
  end

  assign add_out = (am_busy && am_cnt == LAT) ? am_sum
                   : (am_sum ^ (am_junk | WIDTH'(1)));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state: m_c counts cycles since the grant cycle.
  bit               m_free = 1'b1;
  int               m_c    = 0;
  int               m_ptr  = 0;
  int               m_id   = 0;
  logic [WIDTH-1:0] m_a    = '0;
  logic [WIDTH-1:0] m_b    = '0;
  logic [WIDTH-1:0] m_sum  = '0;
  logic [WIDTH-1:0] last_data = '0;
  int               grants[$];

  function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
`ifdef ADD_ARB_PRIO0_EN
    if (r[0]) return 0;
    for (int k = 0; k < NREQ; k++)
      if (((ptr + k) % NREQ) != 0 && r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
`else
    for (int k = 0; k < NREQ; k++)
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
`endif
    return -1;
  endfunction

  // One clock: predict from inputs seen at the edge, then compare outputs.
  task automatic tick();
    logic [NREQ-1:0]       r0;
    logic [NREQ*WIDTH-1:0] a0, b0;
    bit                    rdy0, free0, granted;
    int                    c0, w;
    r0 = req; a0 = req_a; b0 = req_b; rdy0 = rsp_ready;
    free0 = m_free; c0 = m_c; granted = 1'b0; w = 0;
    @(posedge clk); #1;
    if (free0) begin
      if (r0 != '0) begin
        w = pick(r0, m_ptr);
`ifdef ADD_ARB_PRIO0_EN
        if (w != 0) m_ptr = (w + 1) % NREQ;
`else
        m_ptr = (w + 1) % NREQ;
`endif
        m_free = 1'b0;
        m_c    = 0;
        m_id   = w;
        m_a    = a0[w*WIDTH +: WIDTH];
        m_b    = b0[w*WIDTH +: WIDTH];
        m_sum  = WIDTH'(({24'd0, m_a} + {24'd0, m_b}) % (1 << WIDTH));
        granted = 1'b1;
        grants.push_back(w);
        req[w] = 1'b0;
      end
    end else if (c0 == LAT + 2) begin
      if (rdy0) begin
        m_free    = 1'b1;
        last_data = m_sum;
      end
    end else begin
      m_c = c0 + 1;
    end
    chk("gnt", 32'(gnt), granted ? (32'd1 << w) : 32'd0);
    chk("add_en", 32'(add_en), 32'(!m_free && (m_c == 0 || m_c == LAT + 1)));
    chk("rsp_valid", 32'(rsp_valid), 32'(!m_free && m_c == LAT + 2));
    if (!m_free && m_c == LAT + 2) begin
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
      chk("rsp_data", 32'(rsp_data), 32'(m_sum));
    end
    chk("add_a", 32'(add_a), 32'(m_a));
    chk("add_b", 32'(add_b), 32'(m_b));
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (!(m_free && req == '0) && k < 2000) begin
      tick();
      k++;
    end
    chk(tag, 32'(m_free && req == '0), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_add_en"}, 32'(add_en), 32'd0);
    chk({tag, "_add_a"}, 32'(add_a), 32'd0);
    chk({tag, "_add_b"}, 32'(add_b), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_reset(tag);
    m_free = 1'b1; m_c = 0; m_ptr = 0; m_a = '0; m_b = '0;
    req = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  int exp_order[5];
  int k;
  int base;

  initial begin
    req = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    #2;
    do_reset("rst0");
    repeat (2) tick();

    // Single requester
    set_op(2, 8'h35, 8'h4A);
    req[2] = 1'b1;
    drain("single_done");
    chk("single_id", 32'(grants[grants.size()-1]), 32'd2);
    chk("single_sum", 32'(last_data), 32'h7F);

    // All four held: grant order from a fresh pointer
    do_reset("rst1");
    for (int i = 0; i < NREQ; i++) set_op(i, WIDTH'($urandom), WIDTH'($urandom));
    base = grants.size();
    req = '1;
    k = 0;
    while (grants.size() < base + 5 && k < 5 * (LAT + 6) + 20) begin
      tick();
      req = '1;
      k++;
    end
`ifdef ADD_ARB_PRIO0_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    chk("order_count", 32'(grants.size() - base), 32'd5);
    for (int i = 0; i < 5; i++)
      if (base + i < grants.size()) chk($sformatf("order_%0d", i), 32'(grants[base+i]), 32'(exp_order[i]));
    req = '0;
    drain("order_done");

    // Overflow wraps modulo 2^WIDTH
    set_op(1, 8'hFF, 8'h01);
    req[1] = 1'b1;
    drain("ovf1_done");
    chk("ovf1_sum", 32'(last_data), 32'h00);
    set_op(3, 8'h80, 8'h80);
    req[3] = 1'b1;
    drain("ovf2_done");
    chk("ovf2_sum", 32'(last_data), 32'h00);

    // Backpressure: response held, no grant or launch while stalled
    rsp_ready = 1'b0;
    set_op(0, 8'h12, 8'h34);
    req[0] = 1'b1;
    k = 0;
    while (!(!m_free && m_c == LAT + 2) && k < 3 * LAT) begin
      tick();
      k++;
    end
    chk("bp_reach_resp", 32'(!m_free && m_c == LAT + 2), 32'd1);
    set_op(1, 8'h21, 8'h43);
    set_op(2, 8'h0F, 8'hF0);
    req[1] = 1'b1;
    req[2] = 1'b1;
    repeat (20) tick();
    rsp_ready = 1'b1;
    drain("bp_done");
    chk("bp_sum", 32'(last_data), 32'(8'h0F + 8'hF0));

    // Reset during WAIT at lat_cnt == 5
    set_op(3, 8'h11, 8'h22);
    req[3] = 1'b1;
    k = 0;
    while (!(!m_free && m_c == 6) && k < 3 * LAT) begin
      tick();
      k++;
    end
    chk("rw_reach_wait", 32'(!m_free && m_c == 6), 32'd1);
    do_reset("rst_wait");
    repeat (3) tick();
    set_op(1, 8'h05, 8'h07);
    set_op(3, 8'h09, 8'h0B);
    req = 4'b1010;
    drain("rw_done");
    chk("rw_last_id", 32'(grants[grants.size()-1]), 32'd3);
    chk("rw_last_sum", 32'(last_data), 32'h14);

    // Randomized traffic
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i]) begin
          if ($urandom_range(3) == 0) begin
            set_op(i, WIDTH'($urandom), WIDTH'($urandom));
            req[i] = 1'b1;
          end
        end else if ($urandom_range(31) == 0) begin
          req[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(3) != 0);
      tick();
    end
    rsp_ready = 1'b1;
    drain("rand_done");

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
